// File: rtl/sd_fifo_burst_sched.sv
// Read-side burst scheduler: streams whole SD blocks out of the data FIFO.
// Optional WAIT_DATA watchdog enabled by defining SD_FIFO_SCHED_TIMEOUT_EN.
module sd_fifo_burst_sched #(
    parameter int BLK_LEN     = 512,
    parameter int BLK_W       = 16,
    parameter int WCNT_W      = 10,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [BLK_W-1:0] blk_count,
    input  logic             abort,
    input  logic             fifo_empty,
    input  logic             fifo_half,
    input  logic             sd_ready,
    output logic             rd_strb,
    output logic             data_vld,
    output logic             blk_start,
    output logic             blk_done,
    output logic             done,
    output logic             busy,
    output logic [BLK_W-1:0] blks_left,
    output logic             err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_DATA = 3'd1;
    localparam logic [2:0] S_WAIT_SD   = 3'd2;
    localparam logic [2:0] S_BURST     = 3'd3;
    localparam logic [2:0] S_BLK_END   = 3'd4;

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(BLK_LEN - 1);

    logic [2:0]        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [BLK_W-1:0]  left_q, left_d;
    logic              rd_q, rd_d;
    logic              vld_q;
    logic              bs_q, bs_d;
    logic              bd_q, bd_d;
    logic              done_q, done_d;
    logic              busy_q;

`ifdef SD_FIFO_SCHED_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        left_d  = left_q;
        rd_d    = 1'b0;
        bs_d    = 1'b0;
        bd_d    = 1'b0;
        done_d  = 1'b0;
`ifdef SD_FIFO_SCHED_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        err_d   = err_q;
`endif
        // abort wins over everything and leaves blks_left untouched
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
`ifdef SD_FIFO_SCHED_TIMEOUT_EN
                        err_d  = 1'b0;
                        tcnt_d = '0;
`endif
                        if (blk_count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            left_d  = blk_count;
                            state_d = S_WAIT_DATA;
                        end
                    end
                end
                S_WAIT_DATA: begin
                    if (fifo_half) begin
                        state_d = S_WAIT_SD;
                    end
`ifdef SD_FIFO_SCHED_TIMEOUT_EN
                    else if (tcnt_q == TCNT_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
`endif
                end
                S_WAIT_SD: begin
                    if (sd_ready) begin
                        wcnt_d  = '0;
                        state_d = S_BURST;
                    end
                end
                S_BURST: begin
                    // counter only advances on an issued strobe, so it never wraps
                    if (!fifo_empty) begin
                        rd_d = 1'b1;
                        bs_d = (wcnt_q == '0);
                        if (wcnt_q == WCNT_LAST) begin
                            state_d = S_BLK_END;
                        end else begin
                            wcnt_d = wcnt_q + 1'b1;
                        end
                    end
                end
                S_BLK_END: begin
                    bd_d   = 1'b1;
                    left_d = left_q - BLK_W'(1);
                    if (left_q == BLK_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_DATA;
`ifdef SD_FIFO_SCHED_TIMEOUT_EN
                        tcnt_d  = '0;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            left_q  <= '0;
            rd_q    <= 1'b0;
            vld_q   <= 1'b0;
            bs_q    <= 1'b0;
            bd_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            left_q  <= left_d;
            rd_q    <= rd_d;
            vld_q   <= rd_q;
            bs_q    <= bs_d;
            bd_q    <= bd_d;
            done_q  <= done_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

`ifdef SD_FIFO_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end
    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign err = 1'b0;
`endif

    assign rd_strb   = rd_q;
    assign data_vld  = vld_q;
    assign blk_start = bs_q;
    assign blk_done  = bd_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign blks_left = left_q;

endmodule

// File: tb/tb_sd_fifo_burst_sched.sv
// Bench for sd_fifo_burst_sched: cycle-level vector table plus long burst sequences.
module tb_sd_fifo_burst_sched;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] blk_count;
    logic        abort;
    logic        fifo_empty;
    logic        fifo_half;
    logic        sd_ready;
    logic        rd_strb, data_vld, blk_start, blk_done, done, busy, err;
    logic [15:0] blks_left;

    sd_fifo_burst_sched #(
        .BLK_LEN    (512),
        .BLK_W      (16),
        .WCNT_W     (10),
        .TIMEOUT_CYC(50)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .blk_count (blk_count),
        .abort     (abort),
        .fifo_empty(fifo_empty),
        .fifo_half (fifo_half),
        .sd_ready  (sd_ready),
        .rd_strb   (rd_strb),
        .data_vld  (data_vld),
        .blk_start (blk_start),
        .blk_done  (blk_done),
        .done      (done),
        .busy      (busy),
        .blks_left (blks_left),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        start;
        logic [15:0] cnt;
        logic        abort;
        logic        empty;
        logic        half;
        logic        sdr;
        logic [22:0] exp;   // {rd, vld, bs, bd, done, busy, err, blks_left}
    } vec_t;

    vec_t vecs[16];

    int tests = 0;
    int fails = 0;
    int cyc, n_rd, n_bs, n_bd, n_done, n_runs, n_badrun, n_bdbad, first_rd, run;

    function automatic vec_t mk(input logic st, input logic [15:0] c, input logic ab,
                                input logic em, input logic hf, input logic sr,
                                input logic rd, input logic vl, input logic bs,
                                input logic bd, input logic dn, input logic by,
                                input logic [15:0] lf);
        vec_t v;
        v.start = st; v.cnt = c; v.abort = ab; v.empty = em; v.half = hf; v.sdr = sr;
        v.exp = {rd, vl, bs, bd, dn, by, 1'b0, lf};
        return v;
    endfunction

    function automatic logic [22:0] obs();
        return {rd_strb, data_vld, blk_start, blk_done, done, busy, err, blks_left};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic clr();
        cyc = 0; n_rd = 0; n_bs = 0; n_bd = 0; n_done = 0;
        n_runs = 0; n_badrun = 0; n_bdbad = 0; first_rd = -1; run = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rd_strb === 1'b1) begin
            n_rd++;
            run++;
            if (first_rd < 0) first_rd = cyc;
        end else if (run != 0) begin
            if (run != 512) n_badrun++;
            n_runs++;
            run = 0;
        end
        if (blk_start === 1'b1) n_bs++;
        if (blk_done === 1'b1) begin
            n_bd++;
            if (!(data_vld === 1'b1 && rd_strb === 1'b0)) n_bdbad++;
        end
        if (done === 1'b1) n_done++;
    endtask

    task automatic do_start(input logic [15:0] c);
        start = 1'b1;
        blk_count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string nm, input int max);
        for (int i = 0; i < max && n_done == 0; i++) tick();
        chk(nm, n_done, 1);
    endtask

    initial begin
        bit waited, stalled;
        int r0;

        reset_n = 1'b0; start = 1'b0; blk_count = '0; abort = 1'b0;
        fifo_empty = 1'b0; fifo_half = 1'b0; sd_ready = 1'b0;
        clr();
        #1;
        chk("reset_state", obs(), 23'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        //           st cnt ab em hf sr   rd vl bs bd dn by left
        vecs[0]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 2, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 2);
        vecs[4]  = mk(1, 5, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 2);
        vecs[5]  = mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1, 2);
        vecs[6]  = mk(0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 2);
        vecs[7]  = mk(0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 2);
        vecs[8]  = mk(0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 1, 2);
        vecs[9]  = mk(0, 0, 0, 0, 1, 1,   1, 0, 1, 0, 0, 1, 2);
        vecs[10] = mk(0, 0, 0, 0, 1, 1,   1, 1, 0, 0, 0, 1, 2);
        vecs[11] = mk(0, 0, 0, 1, 1, 1,   0, 1, 0, 0, 0, 1, 2);
        vecs[12] = mk(0, 0, 0, 1, 1, 1,   0, 0, 0, 0, 0, 1, 2);
        vecs[13] = mk(0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 1, 2);
        vecs[14] = mk(0, 0, 1, 0, 1, 1,   0, 1, 0, 0, 0, 0, 2);
        vecs[15] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2);

        for (int i = 0; i < 16; i++) begin
            start = vecs[i].start; blk_count = vecs[i].cnt; abort = vecs[i].abort;
            fifo_empty = vecs[i].empty; fifo_half = vecs[i].half; sd_ready = vecs[i].sdr;
            @(posedge clk);
            #1;
            tests++;
            if (obs() !== vecs[i].exp) begin
                fails++;
                $display("FAIL vec%0d: got %h expected %h", i, obs(), vecs[i].exp);
            end
        end
        start = 1'b0; abort = 1'b0;

        // single block with flags already satisfied
        clr();
        fifo_half = 1'b1; sd_ready = 1'b1; fifo_empty = 1'b0;
        do_start(16'd1);
        chk("single_left_loaded", blks_left, 1);
        run_until_done("single_done", 2000);
        chk("single_first_rd_cycle", first_rd, 4);
        chk("single_strobes", n_rd, 512);
        chk("single_runs", n_runs, 1);
        chk("single_badrun", n_badrun, 0);
        chk("single_blk_start", n_bs, 1);
        chk("single_blk_done", n_bd, 1);
        chk("single_bd_align", n_bdbad, 0);
        chk("single_left_end", blks_left, 0);
        tick();
        chk("single_idle_busy", busy, 0);

        // three blocks, fifo_half low for 100 cycles before block 2
        clr();
        waited = 0;
        do_start(16'd3);
        for (int i = 0; i < 6000 && n_done == 0; i++) begin
            tick();
            if (n_bd == 1 && !waited) begin
                waited = 1;
                chk("three_left_after_b1", blks_left, 2);
                fifo_half = 1'b0;
                r0 = n_rd;
                repeat (100) tick();
                chk("three_no_rd_in_wait", n_rd - r0, 0);
                chk("three_busy_in_wait", busy, 1);
                fifo_half = 1'b1;
            end
        end
        chk("three_done", n_done, 1);
        chk("three_strobes", n_rd, 1536);
        chk("three_blk_done", n_bd, 3);
        chk("three_blk_start", n_bs, 3);
        chk("three_badrun", n_badrun, 0);
        chk("three_bd_align", n_bdbad, 0);

        // empty stall at word 200
        clr();
        stalled = 0;
        do_start(16'd1);
        for (int i = 0; i < 2000 && n_done == 0; i++) begin
            tick();
            if (n_rd == 200 && !stalled) begin
                stalled = 1;
                fifo_empty = 1'b1;
                r0 = n_rd;
                repeat (5) tick();
                chk("stall_no_rd", n_rd - r0, 0);
                fifo_empty = 1'b0;
            end
        end
        chk("stall_done", n_done, 1);
        chk("stall_strobes", n_rd, 512);
        chk("stall_blk_start", n_bs, 1);
        chk("stall_blk_done", n_bd, 1);
        chk("stall_run_pieces", n_runs, 2);

        // abort at word 300 of block 2 of 4
        clr();
        do_start(16'd4);
        for (int i = 0; i < 3000 && n_rd < 812; i++) tick();
        chk("abort_reach_word", n_rd, 812);
        abort = 1'b1;
        tick();
        chk("abort_rd_drop", rd_strb, 0);
        chk("abort_last_vld", data_vld, 1);
        chk("abort_busy", busy, 0);
        chk("abort_left", blks_left, 3);
        abort = 1'b0;
        repeat (5) tick();
        chk("abort_no_done", n_done, 0);
        chk("abort_no_more_rd", n_rd, 812);
        chk("abort_blk_done_cnt", n_bd, 1);
        chk("abort_left_held", blks_left, 3);
        clr();
        do_start(16'd1);
        run_until_done("post_abort_done", 2000);
        chk("post_abort_strobes", n_rd, 512);
        chk("post_abort_left", blks_left, 0);

`ifdef SD_FIFO_SCHED_TIMEOUT_EN
        clr();
        fifo_half = 1'b0;
        do_start(16'd1);
        for (int i = 0; i < 200 && busy === 1'b1; i++) tick();
        chk("timeout_cycles", cyc, 51);
        chk("timeout_err", err, 1);
        chk("timeout_no_done", n_done, 0);
        do_start(16'd1);
        chk("timeout_err_clear", err, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        fifo_half = 1'b1;
`else
        chk("err_tied_low", err, 0);
`endif

        // asynchronous reset in the middle of a burst
        clr();
        do_start(16'd2);
        for (int i = 0; i < 1000 && n_rd < 100; i++) tick();
        chk("rst_reach_word", n_rd, 100);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_outputs", obs(), 23'd0);
        repeat (3) tick();
        chk("rst_hold_no_rd", n_rd, 100);
        @(negedge clk) reset_n = 1'b1;
        repeat (4) tick();
        chk("rst_after_no_rd", n_rd, 100);
        chk("rst_after_idle", {busy, blks_left}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
